// File: rtl/gelu_lut_loader.sv
// gelu_lut_loader
//
// Writer side of the GELU coefficient LUT.  Words arrive on a valid/ready
// stream and are written through RAM port A at linear addresses
// 0..NUM_ENTRIES-1 (bank = addr[6:5], index = addr[4:0]).  After the last
// write, every entry is read back through the same port, and the read-back
// sum is compared with the sum of the written words.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle load request, honoured only when idle
//   abort        return to idle from any busy state (wins over start)
//   s_valid      stream word valid
//   s_data       stream word
//   s_ready      registered ready, high only while words are being accepted
//   ram_addr     RAM port A address
//   ram_data     RAM port A write data
//   ram_we       RAM port A write enable
//   ram_q        RAM port A read data, valid one cycle after ram_addr
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse when the read-back compare finishes
//   error        read-back checksum mismatch, held until the next load starts
//   checksum     wrapping sum of the written words, held after a load
module gelu_lut_loader #(
  parameter int ADDR_WIDTH  = 7,
  parameter int LUT_BITS    = 16,
  parameter int NUM_ENTRIES = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [LUT_BITS-1:0]   s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [LUT_BITS-1:0]   ram_data,
  output logic                  ram_we,
  input  logic [LUT_BITS-1:0]   ram_q,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LUT_BITS-1:0]   checksum
);

  // One spare bit so the counter can hold NUM_ENTRIES itself during read-back.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ENTRIES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    CHECK
  } state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic [LUT_BITS-1:0] read_sum;
  logic [LUT_BITS-1:0] read_sum_next;

  assign count_next    = count + 1'b1;
  assign read_sum_next = read_sum + ram_q;

  // LOAD keeps accepting until the last handshake; the cycle after it
  // (s_ready already low) carries the final write and is the drain cycle
  // that hands over to VERIFY.
  //
  // In VERIFY, count is the number of cycles spent there: ram_addr shows
  // entry count, and ram_q carries entry count-1 once count >= 1.  When
  // count reaches NUM_ENTRIES the last read word is on ram_q, so the compare
  // folds that word in directly and the result lands together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      read_sum <= '0;
      s_ready  <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;

      if (abort && (state != IDLE)) begin
        state    <= IDLE;
        s_ready  <= 1'b0;
        busy     <= 1'b0;
        error    <= 1'b0;
        count    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state    <= LOAD;
              s_ready  <= 1'b1;
              busy     <= 1'b1;
              error    <= 1'b0;
              checksum <= '0;
              count    <= '0;
              ram_addr <= '0;
            end
          end

          LOAD: begin
            if (!s_ready) begin
              state    <= VERIFY;
              count    <= '0;
              read_sum <= '0;
              ram_addr <= '0;
            end else if (s_valid) begin
              ram_we   <= 1'b1;
              ram_addr <= count[ADDR_WIDTH-1:0];
              ram_data <= s_data;
              checksum <= checksum + s_data;
              count    <= count_next;
              if (count == LAST_CNT) begin
                s_ready <= 1'b0;
              end
            end
          end

          VERIFY: begin
            if (count != '0) begin
              read_sum <= read_sum_next;
            end
            if (count == FULL_CNT) begin
              state <= CHECK;
              done  <= 1'b1;
              error <= (read_sum_next != checksum);
            end else begin
              count <= count_next;
              if (count != LAST_CNT) begin
                ram_addr <= count_next[ADDR_WIDTH-1:0];
              end
            end
          end

          CHECK: begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end

          default: begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gelu_lut_loader.sv
// tb_gelu_lut_loader
//
// Self-checking bench for gelu_lut_loader.  A RAM model answers port A, a
// stream driver feeds words, and a behavioural model built from event
// timestamps (start cycle, handshake count, last-handshake cycle) gives the
// expected outputs, which are compared on every falling edge.
module tb_gelu_lut_loader;

  localparam int N = 96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [6:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_q = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  gelu_lut_loader #(
    .ADDR_WIDTH(7),
    .LUT_BITS(16),
    .NUM_ENTRIES(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_we(ram_we),
    .ram_q(ram_q),
    .busy(busy),
    .done(done),
    .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // RAM port A; entry 40 can be made to read back with bit 0 flipped.
  logic [15:0] mem [128];
  bit          corrupt_on = 1'b0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr] ^ ((corrupt_on && ram_addr == 7'd40) ? 16'h0001 : 16'h0000);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state.
  bit          m_run = 1'b0;
  int          m_hs = 0;
  int          m_last = -1000;
  logic [15:0] m_sum = '0;
  bit          m_err = 1'b0;
  bit          m_err_final = 1'b0;
  bit          m_we = 1'b0;
  int          m_waddr = 0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_words [N];
  bit          m_hs_now;
  logic [15:0] m_rsum;

  // Bench-side bookkeeping.
  logic [15:0] stim_words [N];
  int          last_hs_cyc = 0;
  int          wr_count = 0;
  int          first_w = -1;
  int          last_w = -1;
  int          done_pulses = 0;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update: on each rising edge, consume the inputs of the cycle that
  // just ended and advance the expected picture for the next cycle.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0;
        m_hs  = 0;
        m_sum = '0;
        m_err = 1'b0;
        m_we  = 1'b0;
      end else begin
        m_hs_now = m_run && (m_hs < N) && s_valid && !abort;
        m_we = m_hs_now;
        if (m_hs_now) begin
          m_waddr = m_hs;
          m_wdata = s_data;
          m_words[m_hs] = s_data;
          m_sum = m_sum + s_data;
          m_hs++;
          if (m_hs == N) begin
            m_last = cyc;
            m_rsum = '0;
            for (int i = 0; i < N; i++)
              m_rsum = m_rsum + (m_words[i] ^ ((corrupt_on && i == 40) ? 16'h0001 : 16'h0000));
            m_err_final = (m_rsum != m_sum);
          end
        end
        if (m_run && abort) begin
          m_run = 1'b0;
          m_err = 1'b0;
        end else if (m_run && m_hs == N && cyc == m_last + 99) begin
          m_run = 1'b0;
          m_err = m_err_final;
        end else if (!m_run && start && !abort) begin
          m_run = 1'b1;
          m_hs  = 0;
          m_sum = '0;
          m_err = 1'b0;
          m_we  = 1'b0;
        end
        cyc++;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("busy", int'(busy), int'(m_run));
        check_output("s_ready", int'(s_ready), int'(m_run && m_hs < N));
        check_output("ram_we", int'(ram_we), int'(m_we));
        if (m_we) begin
          check_output("write addr", int'(ram_addr), m_waddr);
          check_output("write data", int'(ram_data), int'(m_wdata));
        end else if (m_run && m_hs == N && cyc >= m_last + 2 && cyc <= m_last + 97) begin
          check_output("verify addr", int'(ram_addr), cyc - m_last - 2);
        end
        check_output("done", int'(done), int'(m_run && m_hs == N && cyc == m_last + 99));
        check_output("error", int'(error),
                     int'((m_run && m_hs == N && cyc >= m_last + 99) ? m_err_final : m_err));
        check_output("checksum", int'(checksum), int'(m_sum));
        if (ram_we) begin
          wr_count++;
          if (first_w < 0) first_w = cyc;
          last_w = cyc;
        end
        if (done) done_pulses++;
      end
    end
  end

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    wr_count = 0;
    first_w = -1;
    last_w = -1;
    done_pulses = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams stim_words; gap_mode 0 = always valid, 1 = toggling, 2 = random.
  // Optionally re-pulses start at a given count, or stops at reset_at words.
  task automatic apply_stimulus(input int gap_mode, input int start_again_at, input int reset_at);
    int  k = 0;
    int  guard = 0;
    int  phase = 0;
    bit  pulsed = 1'b0;
    bit  hs;
    bit  v;
    while (k < N && guard < 2000 && !(reset_at >= 0 && k == reset_at)) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (phase % 2 == 0);
        default: v = bit'($urandom_range(0, 1));
      endcase
      phase++;
      s_valid = v;
      s_data  = stim_words[k];
      if (k == start_again_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) last_hs_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (hs) k++;
      guard++;
    end
    s_valid = 1'b0;
    if (reset_at < 0) check_output("words accepted", k, N);
  endtask

  task automatic wait_done(input string tag, input bit exp_err, input logic [15:0] exp_sum);
    bit seen = 1'b0;
    int dc = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    check_output({tag, " done seen"}, int'(seen), 1);
    if (seen) begin
      check_output({tag, " done latency"}, dc - last_hs_cyc, 99);
      check_output({tag, " error at done"}, int'(error), int'(exp_err));
      check_output({tag, " checksum at done"}, int'(checksum), int'(exp_sum));
    end
  endtask

  task automatic fill_linear();
    for (int k = 0; k < N; k++) stim_words[k] = 16'(3 * k);
  endtask

  initial begin
    logic [15:0] exp_sum;
    bit          found;
    bit          corrupt_pick;

    #2;
    check_output("reset ram_we", int'(ram_we), 0);
    check_output("reset s_ready", int'(s_ready), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset error", int'(error), 0);
    check_output("reset checksum", int'(checksum), 0);
    check_output("reset ram_addr", int'(ram_addr), 0);
    check_output("reset ram_data", int'(ram_data), 0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] full load, always valid");
    fill_linear();
    start_load();
    apply_stimulus(0, -1, -1);
    wait_done("full", 1'b0, 16'h3570);
    check_output("model checksum", int'(m_sum), 16'h3570);
    check_output("full write count", wr_count, 96);
    check_output("full writes consecutive", last_w - first_w, 95);
    repeat (3) @(negedge clk);
    check_output("full done pulses", done_pulses, 1);
    check_output("checksum held idle", int'(checksum), 16'h3570);

    $display("[TB] toggled valid");
    start_load();
    apply_stimulus(1, -1, -1);
    wait_done("toggle", 1'b0, 16'h3570);
    check_output("toggle write count", wr_count, 96);

    $display("[TB] corrupted read-back at entry 40");
    corrupt_on = 1'b1;
    start_load();
    apply_stimulus(0, -1, -1);
    wait_done("corrupt", 1'b1, 16'h3570);
    repeat (3) @(negedge clk);
    check_output("error held idle", int'(error), 1);
    corrupt_on = 1'b0;
    start_load();
    apply_stimulus(0, -1, -1);
    wait_done("clean after corrupt", 1'b0, 16'h3570);

    $display("[TB] start re-pulsed at count 50");
    start_load();
    apply_stimulus(0, 50, -1);
    wait_done("restart ignored", 1'b0, 16'h3570);
    repeat (5) @(negedge clk);
    check_output("restart write count", wr_count, 96);
    check_output("restart done pulses", done_pulses, 1);

    $display("[TB] reset mid-load at count 20");
    start_load();
    apply_stimulus(0, -1, 20);
    check_output("we before reset", int'(ram_we), 1);
    check_output("checksum at count 20", int'(checksum), 570);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset ram_we", int'(ram_we), 0);
    check_output("async reset s_ready", int'(s_ready), 0);
    check_output("async reset busy", int'(busy), 0);
    check_output("async reset checksum", int'(checksum), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle after reset busy", int'(busy), 0);
    check_output("idle after reset s_ready", int'(s_ready), 0);
    start_load();
    apply_stimulus(0, -1, -1);
    wait_done("after reset", 1'b0, 16'h3570);

    $display("[TB] abort during verify at address 10");
    start_load();
    apply_stimulus(0, -1, -1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (busy && !s_ready && !ram_we && ram_addr == 7'd10) found = 1'b1;
    end
    check_output("verify addr 10 reached", int'(found), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_output("abort busy", int'(busy), 0);
    check_output("abort s_ready", int'(s_ready), 0);
    check_output("abort ram_we", int'(ram_we), 0);
    check_output("abort error", int'(error), 0);
    repeat (110) @(negedge clk);
    check_output("abort done pulses", done_pulses, 0);

    $display("[TB] start with abort in idle");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("start+abort busy", int'(busy), 0);
    end

    $display("[TB] random loads");
    for (int r = 0; r < 4; r++) begin
      exp_sum = '0;
      for (int k = 0; k < N; k++) begin
        stim_words[k] = 16'($urandom);
        exp_sum = exp_sum + stim_words[k];
      end
      corrupt_pick = bit'($urandom_range(0, 1));
      corrupt_on = corrupt_pick;
      start_load();
      apply_stimulus(2, -1, -1);
      wait_done("random", corrupt_pick, exp_sum);
      check_output("random write count", wr_count, 96);
    end
    corrupt_on = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gelu_lut_loader.md
Name: gelu_lut_loader

Overview:
- Writer side of the GELU coefficient LUT. The GELU pipeline only ever reads the dual-port LUT RAM (write enables tied low).
- This block accepts LUT words over a valid/ready stream and writes them through RAM port A. It then reads every entry back through the same port and compares a checksum of the read-back data against a checksum of the written data.
- It sits beside the GELU unit. While `busy`=1, the GELU unit is held off (its `en` is gated by system logic).

Parameters:
- ADDR_WIDTH, 7, RAM address width (bank[1:0] concatenated with index[4:0]).
- LUT_BITS, 16, width of one LUT entry.
- NUM_ENTRIES, 96, words per load: 3 banks of 32. Bank 0 is exponent<0, bank 1 is exponent=0, bank 2 is exponent=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- abort  in  1  returns to IDLE from any state
- s_valid  in  1  stream word valid
- s_data  in  LUT_BITS  stream word
- s_ready  out  1  loader accepts a word
- ram_addr  out  ADDR_WIDTH  RAM port A address
- ram_data  out  LUT_BITS  RAM port A write data
- ram_we  out  1  RAM port A write enable
- ram_q  in  LUT_BITS  RAM port A read data; registered, valid 1 cycle after address
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when verify finishes
- error  out  1  checksum mismatch; held until the next accepted start
- checksum  out  LUT_BITS  checksum of the written words; held after a load

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous, so `ram_we` drops immediately when rst_n goes low, including mid-load.
- States: IDLE, LOAD, VERIFY, CHECK.
- IDLE:
  - start=1 (and abort=0) moves to LOAD next cycle.
  - On that transition: clear `error`, `checksum`, and the address counter.
- LOAD:
  - `s_ready`=1 only in LOAD; it is a registered output, not combinational from `s_valid`.
  - A handshake is `s_valid`&`s_ready`.
  - Each handshake, on the next cycle, drives `ram_we`=1, `ram_addr`=count, `ram_data`=s_data.
  - Each handshake updates `checksum` += s_data (mod 2^LUT_BITS) and increments count.
  - Gaps (`s_valid`=0) insert no writes, and there is no timeout.
  - Linear count k maps to address {k[6:5], k[4:0]}, so entries 0..95 land in banks 0..2. Addresses 96..127 are never written.
  - `s_ready` is 0 in the cycle after the handshake with count=NUM_ENTRIES-1. That final write is issued in that same cycle.
- VERIFY:
  - Entered 2 cycles after the last handshake (cycle t), i.e. at t+2.
  - Drives `ram_we`=0 and `ram_addr`=0,1,..,NUM_ENTRIES-1, one per cycle.
  - Accumulates the read sum from `ram_q` with a 1-cycle lag.
  - The RAM is never read and written in the same cycle.
- CHECK:
  - Entered after the last `ram_q` sample.
  - Compares read sum with `checksum`; sets `error`=1 on mismatch.
  - Pulses `done`=1 and returns to IDLE.
- Latency: `done` is asserted at cycle t+NUM_ENTRIES+3 (t+99 at default).
- `error` and `done` occur together. `checksum` remains valid in IDLE.
- start is ignored while `busy`=1.
- abort:
  - In any non-IDLE state: return to IDLE next cycle, `s_ready`=0 and `ram_we`=0 from that cycle.
  - No `done` pulse; `error` cleared.
  - Partially written RAM contents are left as-is.
  - abort has priority over start in the same cycle.
- `busy` is 1 from the cycle after an accepted start through the CHECK cycle inclusive.
- Arithmetic: both sums are LUT_BITS wide and wrap silently. A wrap is not an error.

Test Plan:
- Full load, s_valid always 1, data=3*k for k=0..95:
  - Writes at addresses 0..95 with `ram_we` pulses on 96 consecutive cycles.
  - checksum = 3*4560 = 13680 (0x3570); `done` at t+99; `error`=0.
- Same data with s_valid toggled 1,0,1,0 by the bench:
  - Exactly 96 writes, addresses still contiguous, checksum 0x3570, `error`=0.
- RAM model flips bit 0 of entry 40 on read-back:
  - `done` and `error`=1 in the same cycle; checksum 0x3570.
  - A following clean load clears `error` to 0.
- Pulse start again at count 50:
  - Ignored; 96 writes total, single `done` pulse.
- Drop rst_n mid-LOAD at count 20:
  - `ram_we`, `s_ready`, `busy`, `checksum` read 0 immediately.
  - After release, state is IDLE and a new start loads normally.
- Assert abort during VERIFY at address 10:
  - IDLE next cycle, no `done` pulse, `error`=0, `busy`=0.
  - Simultaneous start+abort in IDLE leaves the block in IDLE.
